// File: rtl/ms_timer_pkg.sv
// Shared definitions for the millisecond interval timer: state encoding,
// default counter width and common interval lengths.
package ms_timer_pkg;

    // Default width of duration / remaining count in ms (max 4095 ms).
    localparam int DEF_DUR_W = 12;

    // Common interval lengths used by callers.
    localparam int HOLD_2S_MS = 2000;
    localparam int HOLD_1S_MS = 1000;

    // FSM state encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/ms_interval_timer_tick_edge_qual.sv
// Turns the raw 1 ms tick from the LFSR generator into a one-cycle event.
// Only a rising edge is accepted, and only if the generator was enabled in
// the previous cycle, so a tick output left high after the enable drops is
// never mistaken for a new millisecond.
module tick_edge_qual (
    input  logic clk,
    input  logic rst,
    input  logic tick_1ms,
    input  logic tick_enable,
    output logic tick_evt
);

    logic tick_q;
    logic enable_q;

    // Remember last cycle's tick level and generator enable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tick_q   <= 1'b0;
            enable_q <= 1'b0;
        end else begin
            tick_q   <= tick_1ms;
            enable_q <= tick_enable;
        end
    end

    assign tick_evt = tick_1ms & ~tick_q & enable_q;

endmodule

// File: rtl/ms_interval_timer.sv
// Counts qualified 1 ms ticks into programmable intervals, one-shot or
// periodic. Owns the tick generator's enable so the generator restarts from
// its seed at every interval start. Emits a one-cycle done pulse at expiry.
//
// Control handshake: start and abort are single-cycle requests with no
// ready; each is acted on in the cycle it is high. Per cycle abort wins over
// start, and start wins over a tick event. done is a one-cycle registered
// pulse with no backpressure.
module ms_interval_timer
    import ms_timer_pkg::*;
#(
    parameter int DUR_W = DEF_DUR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             repeat_mode,
    input  logic [DUR_W-1:0] duration_ms,
    input  logic             tick_1ms,
    output logic             tick_enable,
    output logic             busy,
    output logic             done,
    output logic [DUR_W-1:0] remaining_ms,
    output logic [1:0]       state_dbg
);

    state_t           state, state_next;
    logic [DUR_W-1:0] rem_next;
    logic [DUR_W-1:0] reload, reload_next;
    logic             rpt, rpt_next;
    logic             done_next;
    logic             ten_next;
    logic             tick_evt;

    tick_edge_qual u_qual (
        .clk         (clk),
        .rst         (rst),
        .tick_1ms    (tick_1ms),
        .tick_enable (tick_enable),
        .tick_evt    (tick_evt)
    );

    assign busy      = (state == ST_RUN);
    assign state_dbg = state;

    // State, counter, latches and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= ST_IDLE;
            remaining_ms <= '0;
            reload       <= '0;
            rpt          <= 1'b0;
            done         <= 1'b0;
            tick_enable  <= 1'b0;
        end else begin
            state        <= state_next;
            remaining_ms <= rem_next;
            reload       <= reload_next;
            rpt          <= rpt_next;
            done         <= done_next;
            tick_enable  <= ten_next;
        end
    end

    // Next-state, counter and output decisions with abort > start > tick.
    always_comb begin
        state_next  = state;
        rem_next    = remaining_ms;
        reload_next = reload;
        rpt_next    = rpt;
        done_next   = 1'b0;
        ten_next    = 1'b0;
        if (abort) begin
            state_next = ST_IDLE;
            rem_next   = '0;
        end else if (start) begin
            rem_next    = duration_ms;
            reload_next = duration_ms;
            rpt_next    = repeat_mode;
            if (duration_ms == '0) begin
                state_next = ST_FIN;
                done_next  = 1'b1;
            end else begin
                state_next = ST_RUN;
                // A restart holds the enable low one cycle so the generator reseeds.
                ten_next   = (state != ST_RUN);
            end
        end else begin
            case (state)
                ST_RUN: begin
                    ten_next = 1'b1;
                    if (tick_evt && remaining_ms != '0) begin
                        if (remaining_ms == DUR_W'(1)) begin
                            done_next = 1'b1;
                            if (rpt) begin
                                rem_next = reload;
                            end else begin
                                rem_next   = '0;
                                state_next = ST_FIN;
                                ten_next   = 1'b0;
                            end
                        end else begin
                            rem_next = remaining_ms - DUR_W'(1);
                        end
                    end
                end
                ST_FIN: begin
                    state_next = ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ms_interval_timer.sv
// Bench for ms_interval_timer. The tick generator is modelled as a one-cycle
// pulse every 8 clocks of continuous tick_enable. Expected outputs come from
// closed-form arithmetic on the cycle offset since start.
module tb_ms_interval_timer;
    import ms_timer_pkg::*;

    localparam int W = DEF_DUR_W;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         repeat_mode = 1'b0;
    logic [W-1:0] duration_ms = '0;
    logic         tick_1ms = 1'b0;
    logic         tick_enable;
    logic         busy;
    logic         done;
    logic [W-1:0] remaining_ms;
    logic [1:0]   state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int gen_run = 0;

    ms_interval_timer #(.DUR_W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .repeat_mode  (repeat_mode),
        .duration_ms  (duration_ms),
        .tick_1ms     (tick_1ms),
        .tick_enable  (tick_enable),
        .busy         (busy),
        .done         (done),
        .remaining_ms (remaining_ms),
        .state_dbg    (state_dbg)
    );

    // Clock.
    always #5 clk = ~clk;

    // Advance one cycle; clear request pulses and run the generator model.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        start = 1'b0;
        abort = 1'b0;
        if (tick_enable) gen_run++;
        else gen_run = 0;
        tick_1ms = (gen_run > 0) && (gen_run % 8 == 0);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input bit b, input bit te, input int rem,
                           input bit d, input int st);
        chk({tag, ":busy"}, 32'(busy), 32'(b));
        chk({tag, ":tick_enable"}, 32'(tick_enable), 32'(te));
        chk({tag, ":remaining"}, 32'(remaining_ms), 32'(rem));
        chk({tag, ":done"}, 32'(done), 32'(d));
        chk({tag, ":state"}, 32'(state_dbg), 32'(st));
    endtask

    task automatic do_start(input int d, input bit rpt, output int s);
        start = 1'b1;
        duration_ms = W'(d);
        repeat_mode = rpt;
        s = cyc;
    endtask

    // Check n cycles of an interval started at cycle s. lag is the number of
    // cycles the generator enable is held off (1 after a restart).
    task automatic run_expect(input string tag, input int s, input int d, input bit rpt,
                              input int lag, input int n, input bit poke);
        int t, k, last;
        bit b, te, dn;
        int rem, st;
        for (int i = 0; i < n; i++) begin
            step();
            t = cyc - s;
            if (poke && t == 1) tick_1ms = 1'b1;
            k = (t - 1 - lag < 0) ? 0 : (t - 1 - lag) / 8;
            if (rpt) begin
                b   = 1'b1;
                te  = (t > lag);
                rem = d - (k % d);
                dn  = (t - 1 - lag > 0) && ((t - 1 - lag) % (8 * d) == 0);
                st  = int'(ST_RUN);
            end else begin
                last = 8 * d + lag;
                b   = (t <= last);
                te  = (t > lag) && (t <= last);
                rem = (t <= last) ? d - k : 0;
                dn  = (t == last + 1);
                st  = b ? int'(ST_RUN) : (dn ? int'(ST_FIN) : int'(ST_IDLE));
            end
            chk_all(tag, b, te, rem, dn, st);
        end
    endtask

    task automatic expect_idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            chk_all(tag, 1'b0, 1'b0, 0, 1'b0, int'(ST_IDLE));
        end
    endtask

    initial begin
        int s, s2, d, t, rem;
        bit rpt;

        // Reset held with the tick input stuck high.
        for (int i = 0; i < 3; i++) begin
            step();
            tick_1ms = 1'b1;
            chk_all("reset", 1'b0, 1'b0, 0, 1'b0, int'(ST_IDLE));
        end
        rst = 1'b1;
        expect_idle("post_reset", 3);

        // One-shot 3 ms.
        do_start(3, 1'b0, s);
        run_expect("oneshot3", s, 3, 1'b0, 0, 30, 1'b0);

        // Periodic 2 ms, aborted right after the 5th tick is counted.
        do_start(2, 1'b1, s);
        run_expect("repeat2", s, 2, 1'b1, 0, 41, 1'b0);
        abort = 1'b1;
        expect_idle("repeat2_abort", 12);

        // Zero duration: done the cycle after start, enable never rises.
        do_start(0, 1'b0, s);
        run_expect("zero", s, 0, 1'b0, 0, 12, 1'b0);

        // Restart after two ticks of a 5 ms interval with a 4 ms one.
        do_start(5, 1'b0, s);
        run_expect("restart_a", s, 5, 1'b0, 0, 17, 1'b0);
        do_start(4, 1'b0, s2);
        run_expect("restart_b", s2, 4, 1'b0, 1, 38, 1'b0);

        // start and abort together while running: abort only.
        do_start(3, 1'b0, s);
        run_expect("sa_run", s, 3, 1'b0, 0, 10, 1'b0);
        start = 1'b1;
        abort = 1'b1;
        duration_ms = W'(6);
        expect_idle("start_abort", 30);

        // Tick held high for 20 cycles counts once.
        do_start(3, 1'b0, s);
        for (int i = 0; i < 46; i++) begin
            step();
            t = cyc - s;
            if (t >= 5 && t <= 24) tick_1ms = 1'b1;
            rem = 3 - int'(t >= 6) - int'(t >= 33) - int'(t >= 41);
            chk_all("hold", t <= 40, t <= 40, rem, t == 41,
                    (t <= 40) ? int'(ST_RUN) : ((t == 41) ? int'(ST_FIN) : int'(ST_IDLE)));
        end

        // Reset mid-run clears everything the next cycle.
        do_start(3, 1'b0, s);
        run_expect("rst_run", s, 3, 1'b0, 0, 12, 1'b0);
        rst = 1'b0;
        step();
        chk_all("rst_mid", 1'b0, 1'b0, 0, 1'b0, int'(ST_IDLE));
        rst = 1'b1;
        expect_idle("rst_after", 10);

        // Randomized intervals; a tick poked while the enable was low is ignored.
        for (int it = 0; it < 6; it++) begin
            d   = int'($urandom_range(1, 6));
            rpt = 1'($urandom_range(0, 1));
            do_start(d, rpt, s);
            if (rpt) begin
                // Abort on the cycle of the second expiring tick: its done is suppressed.
                run_expect("rand_rpt", s, d, 1'b1, 0, 16 * d, 1'b1);
                abort = 1'b1;
                expect_idle("rand_rpt_abort", 12);
            end else begin
                run_expect("rand_one", s, d, 1'b0, 0, 8 * d + 4, 1'b1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
